// File: rtl/ber_readout_master_pkg.sv
// Shared definitions for the GPIO register-file command protocol.
// The register file imports the same package so both ends decode commands identically.
package ber_readout_master_pkg;

    localparam int NBT_GPIOS_DEFAULT      = 32;
    localparam int NBT_COUNT_BITS_DEFAULT = 64;

    // Command opcodes carried in bits [31:24] of a command word
    localparam logic [7:0] CMD_SOFT_RST = 8'h01;
    localparam logic [7:0] CMD_RAM_RD   = 8'h04;
    localparam logic [7:0] CMD_LOG      = 8'h05;
    localparam logic [7:0] CMD_BER_RD   = 8'h06;

    localparam int WR_STROBE_BIT = 23;
    localparam int BER_RD_EN_BIT = 3;

    // Readback word selects: low/high halves of the four accumulators
    localparam logic [2:0] SEL_ERR_I_LO = 3'd0;
    localparam logic [2:0] SEL_ERR_I_HI = 3'd1;
    localparam logic [2:0] SEL_BIT_I_LO = 3'd2;
    localparam logic [2:0] SEL_BIT_I_HI = 3'd3;
    localparam logic [2:0] SEL_ERR_Q_LO = 3'd4;
    localparam logic [2:0] SEL_ERR_Q_HI = 3'd5;
    localparam logic [2:0] SEL_BIT_Q_LO = 3'd6;
    localparam logic [2:0] SEL_BIT_Q_HI = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RAM_OFF,
        ST_LOG_ON,
        ST_LOG_OFF,
        ST_SEL,
        ST_WAIT,
        ST_RELEASE,
        ST_CLR_ON,
        ST_CLR_OFF,
        ST_DONE
    } state_t;

    function automatic logic [31:0] fmt_cmd(input logic [7:0] op, input logic [22:0] payload);
        logic [31:0] word;
        word                = '0;
        word[31:24]         = op;
        word[WR_STROBE_BIT] = 1'b1;
        word[22:0]          = payload;
        return word;
    endfunction

    function automatic logic [22:0] ber_sel_payload(input logic [2:0] k);
        logic [22:0] payload;
        payload                = 23'(k);
        payload[BER_RD_EN_BIT] = 1'b1;
        return payload;
    endfunction

endpackage

// File: rtl/ber_readout_master_if.sv
// Handshake and data bundle between the readout master and its user / register file.
interface ber_readout_master_if
    import ber_readout_master_pkg::*;
#(
    parameter int NBT_GPIOS          = NBT_GPIOS_DEFAULT,
    parameter int NBT_COUNT_BITS_ERR = NBT_COUNT_BITS_DEFAULT
);
    logic                          i_start;
    logic                          i_clear;
    logic [NBT_GPIOS-1:0]          i_gpio_rd;
    logic [NBT_GPIOS-1:0]          o_gpio_wr;
    logic                          o_busy;
    logic                          o_done;
    logic                          o_valid;
    logic [NBT_COUNT_BITS_ERR-1:0] o_err_I;
    logic [NBT_COUNT_BITS_ERR-1:0] o_bit_I;
    logic [NBT_COUNT_BITS_ERR-1:0] o_err_Q;
    logic [NBT_COUNT_BITS_ERR-1:0] o_bit_Q;

    modport master (
        input  i_start, i_clear, i_gpio_rd,
        output o_gpio_wr, o_busy, o_done, o_valid,
        output o_err_I, o_bit_I, o_err_Q, o_bit_Q
    );

    modport slave (
        output i_start, i_clear, i_gpio_rd,
        input  o_gpio_wr, o_busy, o_done, o_valid,
        input  o_err_I, o_bit_I, o_err_Q, o_bit_Q
    );
endinterface

// File: rtl/ber_readout_master.sv
// Hardware initiator that snapshots the BER accumulators through the GPIO command
// protocol and presents them as coherent 64-bit results.
module ber_readout_master
    import ber_readout_master_pkg::*;
#(
    parameter int NBT_GPIOS          = 32,
    parameter int NBT_COUNT_BITS_ERR = 64,
    parameter int SETTLE_CYCLES      = 2
)(
    input  logic                  clk,
    input  logic                  i_reset,
    ber_readout_master_if.master  bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                        state_reg, state_next;
    logic [2:0]                    sel_reg, sel_next;
    logic [CNT_W-1:0]              wait_reg, wait_next;
    logic                          clear_reg, clear_next;
    logic                          sample_en;
    logic [31:0]                   cmd_next;

    logic [NBT_GPIOS-1:0]          gpio_wr_reg;
    logic                          busy_reg;
    logic                          done_reg;
    logic                          valid_reg;
    logic [NBT_COUNT_BITS_ERR-1:0] err_i_reg, bit_i_reg, err_q_reg, bit_q_reg;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            wait_reg  <= '0;
            clear_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            wait_reg  <= wait_next;
            clear_reg <= clear_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        wait_next  = wait_reg;
        clear_next = clear_reg;
        sample_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next = ST_RAM_OFF;
                    clear_next = bus.i_clear;
                end
            end
            ST_RAM_OFF: state_next = ST_LOG_ON;
            ST_LOG_ON:  state_next = ST_LOG_OFF;
            ST_LOG_OFF: begin
                state_next = ST_SEL;
                sel_next   = '0;
            end
            ST_SEL: begin
                state_next = ST_WAIT;
                wait_next  = '0;
            end
            ST_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    sample_en = 1'b1;
                    if (sel_reg == SEL_BIT_Q_HI) begin
                        state_next = ST_RELEASE;
                    end else begin
                        state_next = ST_SEL;
                        sel_next   = sel_reg + 3'd1;
                    end
                end else begin
                    wait_next = wait_reg + CNT_W'(1);
                end
            end
            ST_RELEASE: state_next = clear_reg ? ST_CLR_ON : ST_DONE;
            ST_CLR_ON:  state_next = ST_CLR_OFF;
            ST_CLR_OFF: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The command word is registered alongside the state it belongs to, so
    // o_gpio_wr always reflects the state being presented this cycle.
    always_comb begin
        cmd_next = '0;
        case (state_next)
            ST_RAM_OFF: cmd_next = fmt_cmd(CMD_RAM_RD, 23'd0);
            ST_LOG_ON:  cmd_next = fmt_cmd(CMD_LOG, 23'd1);
            ST_LOG_OFF: cmd_next = fmt_cmd(CMD_LOG, 23'd0);
            ST_SEL:     cmd_next = fmt_cmd(CMD_BER_RD, ber_sel_payload(sel_next));
            ST_RELEASE: cmd_next = fmt_cmd(CMD_BER_RD, 23'd0);
            ST_CLR_ON:  cmd_next = fmt_cmd(CMD_SOFT_RST, 23'd1);
            ST_CLR_OFF: cmd_next = fmt_cmd(CMD_SOFT_RST, 23'd0);
            default:    cmd_next = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shadow
            logic [NBT_GPIOS-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (i_reset) begin
                    word_reg <= '0;
                end else if (sample_en && (sel_reg == 3'(gi))) begin
                    word_reg <= bus.i_gpio_rd;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_reset) begin
            gpio_wr_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            err_i_reg   <= '0;
            bit_i_reg   <= '0;
            err_q_reg   <= '0;
            bit_q_reg   <= '0;
        end else begin
            gpio_wr_reg <= NBT_GPIOS'(cmd_next);
            busy_reg    <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_reg    <= (state_next == ST_DONE);
            if (state_reg == ST_IDLE && bus.i_start) begin
                valid_reg <= 1'b0;
            end
            // Results move only on entry to DONE so all four come from one snapshot
            if (state_next == ST_DONE) begin
                valid_reg <= 1'b1;
                err_i_reg <= NBT_COUNT_BITS_ERR'({g_shadow[SEL_ERR_I_HI].word_reg, g_shadow[SEL_ERR_I_LO].word_reg});
                bit_i_reg <= NBT_COUNT_BITS_ERR'({g_shadow[SEL_BIT_I_HI].word_reg, g_shadow[SEL_BIT_I_LO].word_reg});
                err_q_reg <= NBT_COUNT_BITS_ERR'({g_shadow[SEL_ERR_Q_HI].word_reg, g_shadow[SEL_ERR_Q_LO].word_reg});
                bit_q_reg <= NBT_COUNT_BITS_ERR'({g_shadow[SEL_BIT_Q_HI].word_reg, g_shadow[SEL_BIT_Q_LO].word_reg});
            end
        end
    end

    assign bus.o_gpio_wr = gpio_wr_reg;
    assign bus.o_busy    = busy_reg;
    assign bus.o_done    = done_reg;
    assign bus.o_valid   = valid_reg;
    assign bus.o_err_I   = err_i_reg;
    assign bus.o_bit_I   = bit_i_reg;
    assign bus.o_err_Q   = err_q_reg;
    assign bus.o_bit_Q   = bit_q_reg;

endmodule

// File: tb/tb_ber_readout_master.sv
// Bench for ber_readout_master: two instances (settle 2 and 4) driven in lockstep
// by table entries and random runs, checked cycle by cycle against a timing model.
module tb_ber_readout_master;

    localparam int S_A = 2;
    localparam int S_B = 4;
    localparam logic [3:0][63:0] FIXED_EXP = {64'h1000000710000006, 64'h1000000510000004,
                                              64'h1000000310000002, 64'h1000000110000000};

    typedef struct {
        bit              clr;
        bit              rnd;
        bit              en_a;
        bit              en_b;
        int              inj1;
        int              inj2;
        int              rst_at;
        int              done_a;
        int              done_b;
        logic [3:0][63:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic i_reset;
    always #5 clk = ~clk;

    ber_readout_master_if #(.NBT_GPIOS(32), .NBT_COUNT_BITS_ERR(64)) bus_a ();
    ber_readout_master_if #(.NBT_GPIOS(32), .NBT_COUNT_BITS_ERR(64)) bus_b ();

    ber_readout_master #(.NBT_GPIOS(32), .NBT_COUNT_BITS_ERR(64), .SETTLE_CYCLES(S_A)) u_dut_a (
        .clk(clk), .i_reset(i_reset), .bus(bus_a.master));
    ber_readout_master #(.NBT_GPIOS(32), .NBT_COUNT_BITS_ERR(64), .SETTLE_CYCLES(S_B)) u_dut_b (
        .clk(clk), .i_reset(i_reset), .bus(bus_b.master));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected command word in cycle c of a sequence started at cycle 0
    function automatic logic [31:0] exp_cmd(input int c, input int s, input bit clr);
        int r;
        int off;
        r = 4 + 8 * (1 + s);
        if (c == 1) return 32'h04800000;
        if (c == 2) return 32'h05800001;
        if (c == 3) return 32'h05800000;
        if (c >= 4 && c < r) begin
            off = c - 4;
            if (off % (1 + s) == 0) return 32'h06800008 | 32'(off / (1 + s));
            return 32'h0;
        end
        if (c == r) return 32'h06800000;
        if (clr && c == r + 1) return 32'h01800001;
        if (clr && c == r + 2) return 32'h01800000;
        return 32'h0;
    endfunction

    // Returns the word index sampled at the end of cycle c, or -1
    function automatic int sample_word(input int c, input int s);
        int k;
        if (c < 4 || ((c - 3) % (1 + s)) != 0) return -1;
        k = (c - 3) / (1 + s) - 1;
        if (k < 0 || k > 7) return -1;
        return k;
    endfunction

    task automatic check_inst(input string tag, input int c, input int s, input int dn, input bit clr,
                              input logic [31:0] wr, input logic busy, input logic done,
                              input logic valid, input logic [3:0][63:0] outs,
                              input logic [3:0][63:0] ex);
        check($sformatf("%s gpio_wr c=%0d", tag, c), 64'(wr), 64'(exp_cmd(c, s, clr)));
        check($sformatf("%s busy c=%0d", tag, c), 64'(busy), 64'(c < dn));
        check($sformatf("%s done c=%0d", tag, c), 64'(done), 64'(c == dn));
        check($sformatf("%s valid c=%0d", tag, c), 64'(valid), 64'(c >= dn));
        if (c == dn) begin
            for (int j = 0; j < 4; j++)
                check($sformatf("%s result%0d", tag, j), outs[j], ex[j]);
        end
    endtask

    task automatic check_zero(input string tag, input logic [31:0] wr, input logic busy,
                              input logic done, input logic valid, input logic [3:0][63:0] outs);
        check({tag, " zero gpio_wr"}, 64'(wr), 64'h0);
        check({tag, " zero busy"}, 64'(busy), 64'h0);
        check({tag, " zero done"}, 64'(done), 64'h0);
        check({tag, " zero valid"}, 64'(valid), 64'h0);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s zero result%0d", tag, j), outs[j], 64'h0);
    endtask

    task automatic run_seq(input int idx, input vec_t v);
        logic [31:0]      wa[8];
        logic [31:0]      wb[8];
        logic [3:0][63:0] ea;
        logic [3:0][63:0] eb;
        int               last;
        int               ka;
        int               kb;
        int               ndone_a;
        int               ndone_b;
        for (int k = 0; k < 8; k++) begin
            wa[k] = v.rnd ? $urandom : 32'h10000000 + 32'(k);
            wb[k] = v.rnd ? $urandom : 32'h10000000 + 32'(k);
        end
        for (int j = 0; j < 4; j++) begin
            ea[j] = v.rnd ? {wa[2*j+1], wa[2*j]} : v.exp_out[j];
            eb[j] = v.rnd ? {wb[2*j+1], wb[2*j]} : v.exp_out[j];
        end
        last = 0;
        if (v.en_a) last = v.done_a;
        if (v.en_b && v.done_b > last) last = v.done_b;
        if (v.rst_at >= 0) last = v.rst_at + 1;
        ndone_a = 0;
        ndone_b = 0;

        @(negedge clk);
        bus_a.i_start   = v.en_a;
        bus_b.i_start   = v.en_b;
        bus_a.i_clear   = v.clr;
        bus_b.i_clear   = v.clr;
        bus_a.i_gpio_rd = $urandom;
        bus_b.i_gpio_rd = $urandom;

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            bus_a.i_start = v.en_a && (c == v.inj1 || c == v.inj2);
            bus_b.i_start = v.en_b && (c == v.inj1 || c == v.inj2);
            bus_a.i_clear = $urandom_range(0, 1);
            bus_b.i_clear = $urandom_range(0, 1);
            i_reset       = (c == v.rst_at);
            if (bus_a.o_done) ndone_a++;
            if (bus_b.o_done) ndone_b++;
            if (v.rst_at >= 0 && c == v.rst_at + 1) begin
                check_zero("A", bus_a.o_gpio_wr, bus_a.o_busy, bus_a.o_done, bus_a.o_valid,
                           {bus_a.o_bit_Q, bus_a.o_err_Q, bus_a.o_bit_I, bus_a.o_err_I});
                check_zero("B", bus_b.o_gpio_wr, bus_b.o_busy, bus_b.o_done, bus_b.o_valid,
                           {bus_b.o_bit_Q, bus_b.o_err_Q, bus_b.o_bit_I, bus_b.o_err_I});
            end else begin
                if (v.en_a)
                    check_inst("A", c, S_A, v.done_a, v.clr, bus_a.o_gpio_wr, bus_a.o_busy,
                               bus_a.o_done, bus_a.o_valid,
                               {bus_a.o_bit_Q, bus_a.o_err_Q, bus_a.o_bit_I, bus_a.o_err_I}, ea);
                if (v.en_b)
                    check_inst("B", c, S_B, v.done_b, v.clr, bus_b.o_gpio_wr, bus_b.o_busy,
                               bus_b.o_done, bus_b.o_valid,
                               {bus_b.o_bit_Q, bus_b.o_err_Q, bus_b.o_bit_I, bus_b.o_err_I}, eb);
            end
            // Readback is only meaningful in the sample cycle; garbage otherwise
            ka = sample_word(c, S_A);
            kb = sample_word(c, S_B);
            bus_a.i_gpio_rd = (ka >= 0) ? wa[ka] : $urandom;
            bus_b.i_gpio_rd = (kb >= 0) ? wb[kb] : $urandom;
        end
        if (v.rst_at < 0) begin
            if (v.en_a) check("A done count", 64'(ndone_a), 64'd1);
            if (v.en_b) check("B done count", 64'(ndone_b), 64'd1);
        end
        $display("run %0d clr=%0d rnd=%0d en=%0d%0d rst_at=%0d cycles=%0d total=%0d bad=%0d",
                 idx, v.clr, v.rnd, v.en_a, v.en_b, v.rst_at, last, total, bad);
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v;
        i_reset = 1'b1;
        bus_a.i_start = 1'b0; bus_a.i_clear = 1'b0; bus_a.i_gpio_rd = '0;
        bus_b.i_start = 1'b0; bus_b.i_clear = 1'b0; bus_b.i_gpio_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("A reset", bus_a.o_gpio_wr, bus_a.o_busy, bus_a.o_done, bus_a.o_valid,
                   {bus_a.o_bit_Q, bus_a.o_err_Q, bus_a.o_bit_I, bus_a.o_err_I});
        check_zero("B reset", bus_b.o_gpio_wr, bus_b.o_busy, bus_b.o_done, bus_b.o_valid,
                   {bus_b.o_bit_Q, bus_b.o_err_Q, bus_b.o_bit_I, bus_b.o_err_I});
        i_reset = 1'b0;

        tbl[0] = '{clr:0, rnd:0, en_a:1, en_b:1, inj1:-1, inj2:-1, rst_at:-1, done_a:29, done_b:45, exp_out:FIXED_EXP};
        tbl[1] = '{clr:1, rnd:0, en_a:1, en_b:1, inj1:-1, inj2:-1, rst_at:-1, done_a:31, done_b:47, exp_out:FIXED_EXP};
        tbl[2] = '{clr:0, rnd:1, en_a:1, en_b:1, inj1:-1, inj2:-1, rst_at:-1, done_a:29, done_b:45, exp_out:'0};
        tbl[3] = '{clr:0, rnd:0, en_a:1, en_b:0, inj1:5,  inj2:29, rst_at:-1, done_a:29, done_b:0,  exp_out:FIXED_EXP};
        tbl[4] = '{clr:1, rnd:1, en_a:1, en_b:0, inj1:-1, inj2:-1, rst_at:-1, done_a:31, done_b:0,  exp_out:'0};
        tbl[5] = '{clr:0, rnd:1, en_a:1, en_b:1, inj1:-1, inj2:-1, rst_at:12, done_a:29, done_b:45, exp_out:'0};
        tbl[6] = '{clr:0, rnd:0, en_a:1, en_b:1, inj1:-1, inj2:-1, rst_at:-1, done_a:29, done_b:45, exp_out:FIXED_EXP};
        tbl[7] = '{clr:1, rnd:1, en_a:1, en_b:1, inj1:7,  inj2:30, rst_at:-1, done_a:31, done_b:47, exp_out:'0};

        for (int i = 0; i < 8; i++) run_seq(i, tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.clr     = 1'($urandom_range(0, 1));
            v.rnd     = 1'b1;
            v.en_a    = 1'b1;
            v.en_b    = 1'b1;
            v.inj1    = $urandom_range(1, 25);
            v.inj2    = -1;
            v.rst_at  = -1;
            v.done_a  = v.clr ? 31 : 29;
            v.done_b  = v.clr ? 47 : 45;
            v.exp_out = '0;
            run_seq(8 + i, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ber_readout_master.md
Name: ber_readout_master

Overview:
- Hardware initiator for the GPIO register-file command protocol; it takes the place of the MicroBlaze when reading the BER counters.
- Emits 32-bit command words (opcode [31:24], write strobe bit 23, payload [22:0]) towards the register file.
- Snapshots the four 64-bit error/bit accumulators, reads them back as eight 32-bit words and presents them as coherent 64-bit results.
- Optionally soft-resets the DSP afterwards. Sits beside the register file; used for standalone FPGA builds and as the bench driver.

Parameters:
NBT_GPIOS, 32, command/readback word width
NBT_COUNT_BITS_ERR, 64, accumulator width (must equal 2*NBT_GPIOS)
SETTLE_CYCLES, 2, wait cycles after each select command before sampling readback (>=1)

Ports:
clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  request one readout sequence; sampled only in IDLE
i_clear  in  1  sampled with i_start; 1 = pulse DSP soft reset after readout
i_gpio_rd  in  NBT_GPIOS  readback word from register file
o_gpio_wr  out  NBT_GPIOS  command word to register file
o_busy  out  1  high from the cycle after start acceptance until o_done
o_done  out  1  one-cycle pulse at end of sequence
o_valid  out  1  results valid; cleared on start acceptance
o_err_I, o_bit_I, o_err_Q, o_bit_Q  out  NBT_COUNT_BITS_ERR each  latched counters

Behaviour:
- One clock (clk); reset is synchronous and active-high (i_reset).
- On reset:
  - all outputs are 0 and state is IDLE, including o_gpio_wr = 0x00000000.
  - Reset mid-sequence aborts immediately. No release command is issued. Shadow registers and outputs are cleared.
- All outputs are registered. When no command is being issued, o_gpio_wr = 0 (strobe low).
- Command words, one cycle each:
  - RAM_OFF = 0x04800000
  - LOG_ON = 0x05800001
  - LOG_OFF = 0x05800000
  - SEL(k) = 0x06800008 | k, k = 0..7
  - RELEASE = 0x06800000
  - CLR_ON = 0x01800001
  - CLR_OFF = 0x01800000
- States:
  - IDLE: on i_start, latch i_clear, clear o_valid, go to RAM_OFF.
  - RAM_OFF -> LOG_ON -> LOG_OFF. The register file captures its snapshot in the LOG_OFF cycle.
  - SEL(k): drive SEL(k), then WAIT with o_gpio_wr = 0 for SETTLE_CYCLES.
  - On the last WAIT cycle, register i_gpio_rd into shadow word k. If k < 7, go to SEL(k+1); else go to RELEASE.
  - RELEASE: then CLR_ON, CLR_OFF if clear latched; then DONE.
  - DONE: copy shadows to outputs, o_valid = 1, o_done = 1 for one cycle, go to IDLE.
- Word map:
  - k=0/1: o_err_I low/high
  - k=2/3: o_bit_I low/high
  - k=4/5: o_err_Q low/high
  - k=6/7: o_bit_Q low/high
- Outputs change only in DONE, so the four values always come from the same snapshot.
- Timing: i_start sampled at cycle 0. First command word appears at cycle 1. o_done is high at cycle 5 + 8*(1+SETTLE_CYCLES), plus 2 if clear. Default: 29, or 31 with clear.
- i_start while busy is ignored; it is not queued. i_start in the same cycle as the o_done pulse is ignored. A new start is accepted from the next IDLE cycle.
- Changes on i_gpio_rd outside the sample cycles have no effect.
- o_valid stays high until the next accepted start or reset.

Decomposition:
- Shared package holds:
  - opcodes: CMD_SOFT_RST = 8'h01, CMD_RAM_RD = 8'h04, CMD_LOG = 8'h05, CMD_BER_RD = 8'h06
  - write-strobe bit index 23
  - BER read-enable bit index 3
  - word-select constants 0..7
  - state enum
- Shared with the register file so both ends decode identically.
- No sub-module needed; the command formatter is a function in the package.

Test Plan:
- Bench register file returns 0x10000000+k for select k. Start, no clear -> o_done at cycle 29. Outputs:
  - o_err_I = 0x1000000110000000
  - o_bit_I = 0x1000000310000002
  - o_err_Q = 0x1000000510000004
  - o_bit_Q = 0x1000000710000006
  - o_valid = 1
- o_gpio_wr trace for the start above: 0x04800000, 0x05800001, 0x05800000, 0x06800008, 0, 0, 0x06800009, ..., 0x0680000F, 0, 0, 0x06800000. Strobe is low in every other cycle.
- i_clear = 1 with start -> 0x01800001 then 0x01800000 after RELEASE; o_done at cycle 31.
- i_start pulsed at cycles 5 and 29 of a running sequence -> both ignored; exactly one o_done; the next start is accepted at cycle 30.
- i_reset at cycle 12 -> next cycle all outputs are 0, including o_valid and o_gpio_wr; a subsequent start gives a full 29-cycle sequence.
- SETTLE_CYCLES = 4, and the model changes i_gpio_rd to garbage except in the sample cycle -> sampling occurs exactly on the 4th WAIT cycle; o_done at cycle 45.
